// File: rtl/fft_ctrl_pkg.sv
// Shared types and constants for the SDF FFT stage sequencer.
package fft_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        BFLY  = 2'd2,
        FLUSH = 2'd3
    } state_t;

    localparam logic DOUT_SEL_SUM  = 1'b0;
    localparam logic DOUT_SEL_DIFF = 1'b1;

    localparam int DEFAULT_DATA_HEIGHT = 16;

endpackage

// File: rtl/fft_half_cnt.sv
// Half-frame position counter: wraps naturally at DATA_HEIGHT (a power of two),
// with synchronous clear and a terminal-count flag at DATA_HEIGHT-1.
module fft_half_cnt #(
    parameter int DATA_HEIGHT = 16,
    parameter int CNT_W       = $clog2(DATA_HEIGHT)
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] cnt,
    output logic             tc
);

    always_ff @(posedge clk) begin
        if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    assign tc = (cnt == CNT_W'(DATA_HEIGHT - 1));

endmodule

// File: rtl/fft_sdf_stage_ctrl.sv
// Sequencer for one radix-2 SDF FFT stage: fill half, butterfly half, difference flush.
// Define FFT_SDF_CTRL_ERR_EN to add the sticky err_overrun output.
module fft_sdf_stage_ctrl
    import fft_ctrl_pkg::*;
#(
    parameter int DATA_HEIGHT = DEFAULT_DATA_HEIGHT,
    parameter int CNT_W       = $clog2(DATA_HEIGHT),
    parameter int FRAME_CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   din_valid,
    output logic                   din_ready,
    output logic                   sr_en,
    output logic                   bfly_sel,
    output logic [CNT_W-1:0]       tw_addr,
    output logic                   dout_valid,
    output logic                   dout_sel,
    output logic                   frame_done,
    output logic [FRAME_CNT_W-1:0] frame_cnt
`ifdef FFT_SDF_CTRL_ERR_EN
    ,
    output logic                   err_overrun
`endif
);

    state_t                 state_q;
    state_t                 state_d;
    logic                   pending_q;
    logic [FRAME_CNT_W-1:0] frame_cnt_q;
    logic [CNT_W-1:0]       cnt;
    logic                   cnt_tc;
    logic                   cnt_en;

    fft_half_cnt #(
        .DATA_HEIGHT(DATA_HEIGHT),
        .CNT_W      (CNT_W)
    ) u_half_cnt (
        .clk(clk),
        .clr(~rstn),
        .en (cnt_en),
        .cnt(cnt),
        .tc (cnt_tc)
    );

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A stall at the very start of a fill half with differences outstanding
    // gives up on overlapping them and drains them through FLUSH instead.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (din_valid) state_d = FILL;
            end
            FILL: begin
                if (din_valid && cnt_tc) begin
                    state_d = BFLY;
                end else if (!din_valid && (cnt == '0)) begin
                    state_d = pending_q ? FLUSH : IDLE;
                end
            end
            BFLY: begin
                if (din_valid && cnt_tc) state_d = FILL;
            end
            FLUSH: begin
                if (cnt_tc) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        din_ready  = 1'b0;
        sr_en      = 1'b0;
        bfly_sel   = 1'b0;
        tw_addr    = '0;
        dout_valid = 1'b0;
        dout_sel   = DOUT_SEL_SUM;
        frame_done = 1'b0;
        cnt_en     = 1'b0;
        if (rstn) begin
            case (state_q)
                IDLE: begin
                    din_ready = 1'b1;
                    sr_en     = din_valid;
                    cnt_en    = din_valid;
                end
                FILL: begin
                    din_ready = 1'b1;
                    if (din_valid) begin
                        sr_en      = 1'b1;
                        cnt_en     = 1'b1;
                        dout_valid = pending_q;
                        dout_sel   = pending_q ? DOUT_SEL_DIFF : DOUT_SEL_SUM;
                        frame_done = pending_q && cnt_tc;
                    end
                end
                BFLY: begin
                    din_ready = 1'b1;
                    if (din_valid) begin
                        sr_en      = 1'b1;
                        cnt_en     = 1'b1;
                        bfly_sel   = 1'b1;
                        tw_addr    = cnt;
                        dout_valid = 1'b1;
                    end
                end
                FLUSH: begin
                    sr_en      = 1'b1;
                    cnt_en     = 1'b1;
                    dout_valid = 1'b1;
                    dout_sel   = DOUT_SEL_DIFF;
                    frame_done = cnt_tc;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            pending_q   <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            if (frame_done) begin
                pending_q   <= 1'b0;
                frame_cnt_q <= frame_cnt_q + FRAME_CNT_W'(1);
            end else if ((state_q == BFLY) && din_valid && cnt_tc) begin
                pending_q <= 1'b1;
            end
        end
    end

    assign frame_cnt = rstn ? frame_cnt_q : '0;

`ifdef FFT_SDF_CTRL_ERR_EN
    logic err_q;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            err_q <= 1'b0;
        end else if ((state_q == FLUSH) && din_valid) begin
            err_q <= 1'b1;
        end
    end

    assign err_overrun = rstn & err_q;
`endif

endmodule

// File: tb/tb_fft_sdf_stage_ctrl.sv
// Scoreboard bench for fft_sdf_stage_ctrl: a frame-position model predicts every
// cycle's control outputs, which are queued and compared against the DUT.
module tb_fft_sdf_stage_ctrl;

    localparam int H  = 16;
    localparam int CW = 4;
    localparam int FW = 8;

    logic          clk;
    logic          rstn;
    logic          din_valid;
    logic          din_ready;
    logic          sr_en;
    logic          bfly_sel;
    logic [CW-1:0] tw_addr;
    logic          dout_valid;
    logic          dout_sel;
    logic          frame_done;
    logic [FW-1:0] frame_cnt;
`ifdef FFT_SDF_CTRL_ERR_EN
    logic          err_overrun;
`endif

    fft_sdf_stage_ctrl #(
        .DATA_HEIGHT(H),
        .CNT_W      (CW),
        .FRAME_CNT_W(FW)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .sr_en      (sr_en),
        .bfly_sel   (bfly_sel),
        .tw_addr    (tw_addr),
        .dout_valid (dout_valid),
        .dout_sel   (dout_sel),
        .frame_done (frame_done),
        .frame_cnt  (frame_cnt)
`ifdef FFT_SDF_CTRL_ERR_EN
        ,
        .err_overrun(err_overrun)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ctrl = {din_ready, sr_en, bfly_sel, dout_valid, dout_sel, frame_done}
    typedef struct packed {
        logic [5:0]    ctrl;
        logic [CW-1:0] tw;
        logic [FW-1:0] fcnt;
        logic          err;
    } exp_t;

    exp_t sb[$];

    int checks   = 0;
    int errors   = 0;
    int fd_seen  = 0;

    // Model: position within the 2*H-sample frame, outstanding differences,
    // and the flush drain index.
    int            m_pos   = 0;
    bit            m_pend  = 0;
    bit            m_flush = 0;
    int            m_fidx  = 0;
    logic [FW-1:0] m_fcnt  = '0;
    bit            m_err   = 0;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s @%0t: got 0x%0h, expected 0x%0h",
                     tag, $time, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic r);
        exp_t e;
        logic bf, dv, sel, fd;
        e = '0;
        @(negedge clk);
        rstn      = r;
        din_valid = v;
        if (!r) begin
            m_pos   = 0;
            m_pend  = 0;
            m_flush = 0;
            m_fidx  = 0;
            m_fcnt  = '0;
            m_err   = 0;
        end else if (m_flush) begin
            fd     = (m_fidx == H - 1);
            e.ctrl = {1'b0, 1'b1, 1'b0, 1'b1, 1'b1, fd};
            e.fcnt = m_fcnt;
            e.err  = m_err;
            if (v) m_err = 1;
            if (fd) begin
                m_flush = 0;
                m_fidx  = 0;
                m_pend  = 0;
                m_fcnt  = m_fcnt + 1'b1;
            end else begin
                m_fidx++;
            end
        end else begin
            e.fcnt = m_fcnt;
            e.err  = m_err;
            if (v) begin
                if (m_pos < H) begin
                    bf  = 1'b0;
                    dv  = m_pend;
                    sel = m_pend;
                    fd  = m_pend && (m_pos == H - 1);
                end else begin
                    bf   = 1'b1;
                    dv   = 1'b1;
                    sel  = 1'b0;
                    fd   = 1'b0;
                    e.tw = CW'(m_pos - H);
                end
                e.ctrl = {1'b1, 1'b1, bf, dv, sel, fd};
                m_pos++;
                if (m_pos == 2 * H) begin
                    m_pos  = 0;
                    m_pend = 1;
                end
                if (fd) begin
                    m_pend = 0;
                    m_fcnt = m_fcnt + 1'b1;
                end
            end else begin
                e.ctrl = 6'b100000;
                if (m_pos == 0 && m_pend) m_flush = 1;
            end
        end
        sb.push_back(e);
        #1;
        e = sb.pop_front();
        checkOutput("ctrl", {26'd0, din_ready, sr_en, bfly_sel, dout_valid, dout_sel, frame_done},
                    {26'd0, e.ctrl});
        checkOutput("tw_addr", {28'd0, tw_addr}, {28'd0, e.tw});
        checkOutput("frame_cnt", {24'd0, frame_cnt}, {24'd0, e.fcnt});
`ifdef FFT_SDF_CTRL_ERR_EN
        checkOutput("err_overrun", {31'd0, err_overrun}, {31'd0, e.err});
`endif
        if (frame_done === 1'b1) fd_seen++;
    endtask

    initial begin
        rstn      = 1'b0;
        din_valid = 1'b0;

        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0);

        // Single frame, then idle long enough to drain via FLUSH
        for (int i = 0; i < 32; i++) applyStimulus(1'b1, 1'b1);
        for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'b1);

        // Back-to-back frames with overlapped differences
        for (int i = 0; i < 64; i++) applyStimulus(1'b1, 1'b1);
        for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'b1);

        // Alternating gaps across two frames
        for (int i = 0; i < 128; i++) applyStimulus(((i % 2) == 0), 1'b1);
        for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'b1);

        // Reset while in the butterfly half at cnt=7
        for (int i = 0; i < 23; i++) applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1);

        // Valid asserted in the middle of a flush
        for (int i = 0; i < 60; i++) applyStimulus((i < 32) || (i == 40), 1'b1);

        // Frame counter wrap after 256 frames
        applyStimulus(1'b0, 1'b0);
        fd_seen = 0;
        for (int f = 0; f < 256; f++) begin
            for (int i = 0; i < 50; i++) applyStimulus((i < 32), 1'b1);
        end
        checkOutput("wrap_frame_cnt", {24'd0, frame_cnt}, 32'd0);
        checkOutput("wrap_frame_done_count", fd_seen, 32'd256);

        // Random valid pattern
        for (int i = 0; i < 400; i++) applyStimulus(($urandom_range(0, 3) != 0), 1'b1);
        for (int i = 0; i < 40; i++) applyStimulus(1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        errors++;
        $display("[TB] FAIL timeout: got no completion, expected finish before 1000000");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
